// File: rtl/dmem_arbiter_if.sv
// Shared data-memory bus: two requester ports plus the single memory port.
// The arbiter takes the slave view; requesters and memory sit on the master side.
interface dmem_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  p0_req;
  logic                  p0_we;
  logic [DM_ADDRESS-1:0] p0_addr;
  logic [DATA_W-1:0]     p0_wdata;
  logic [2:0]            p0_funct3;
  logic                  p0_gnt;
  logic                  p0_rvalid;
  logic [DATA_W-1:0]     p0_rdata;
  logic                  p0_err;

  logic                  p1_req;
  logic                  p1_we;
  logic [DM_ADDRESS-1:0] p1_addr;
  logic [DATA_W-1:0]     p1_wdata;
  logic [2:0]            p1_funct3;
  logic                  p1_gnt;
  logic                  p1_rvalid;
  logic [DATA_W-1:0]     p1_rdata;
  logic                  p1_err;

  logic                  MemRead;
  logic                  MemWrite;
  logic [DM_ADDRESS-1:0] a;
  logic [DATA_W-1:0]     wd;
  logic [2:0]            Funct3;
  logic [DATA_W-1:0]     rd;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_funct3,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_funct3,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output MemRead, MemWrite, a, wd, Funct3,
    input  rd
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_funct3,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_funct3,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  MemRead, MemWrite, a, wd, Funct3,
    output rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the shared data-memory port, with alignment
// checking and a registered one-cycle response per requester.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  logic [1:0]            w_req;
  logic                  w_any;
  logic                  w_win;
  logic                  w_we;
  logic [DM_ADDRESS-1:0] w_addr;
  logic [DATA_W-1:0]     w_wdata;
  logic [2:0]            w_f3;
  logic                  w_ok;
  logic                  w_go;
  logic                  w_v0;
  logic                  w_v1;

  logic                  r_last;
  logic                  r_vld;
  logic                  r_port;
  logic                  r_err;
  logic [DATA_W-1:0]     r_data;

  function automatic logic f_legal(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b100:  ok = ~we;
      3'b001:  ok = ~lo[0];
      3'b101:  ok = ~we & ~lo[0];
      3'b010:  ok = (lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign w_req = {bus.p1_req, bus.p0_req};
  // Requests are ignored while reset is held.
  assign w_any = rst_n & (|w_req);
  assign w_win = (w_req == 2'b11) ? ~r_last : w_req[1];

  assign w_we    = w_win ? bus.p1_we     : bus.p0_we;
  assign w_addr  = w_win ? bus.p1_addr   : bus.p0_addr;
  assign w_wdata = w_win ? bus.p1_wdata  : bus.p0_wdata;
  assign w_f3    = w_win ? bus.p1_funct3 : bus.p0_funct3;

  assign w_ok = f_legal(w_we, w_f3, w_addr[1:0]);
  assign w_go = w_any & w_ok;

  assign bus.p0_gnt = w_any & ~w_win;
  assign bus.p1_gnt = w_any & w_win;

  assign bus.MemRead  = w_go & ~w_we;
  assign bus.MemWrite = w_go & w_we;
  assign bus.a        = w_any ? w_addr  : '0;
  assign bus.wd       = w_any ? w_wdata : '0;
  assign bus.Funct3   = w_any ? w_f3    : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_vld  <= 1'b0;
      r_port <= 1'b0;
      r_err  <= 1'b0;
      r_data <= '0;
    end else begin
      r_vld <= w_any;
      if (w_any) begin
        r_last <= w_win;
        r_port <= w_win;
        r_err  <= ~w_ok;
        r_data <= (w_ok & ~w_we) ? bus.rd : '0;
      end
    end
  end

  // A response pending when reset arrives is dropped.
  assign w_v0 = rst_n & r_vld & ~r_port;
  assign w_v1 = rst_n & r_vld & r_port;

  assign bus.p0_rvalid = w_v0;
  assign bus.p1_rvalid = w_v1;
  assign bus.p0_rdata  = w_v0 ? r_data : '0;
  assign bus.p1_rdata  = w_v1 ? r_data : '0;
  assign bus.p0_err    = w_v0 & r_err;
  assign bus.p1_err    = w_v1 & r_err;

endmodule
